// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, state encoding and default timing for the
//               HD44780 16x2 frame writer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int c_t_pwrup_def  = 1_500_000;
    localparam int c_t_setup_def  = 4;
    localparam int c_t_ehigh_def  = 25;
    localparam int c_t_hold_def   = 4;
    localparam int c_t_nibble_def = 100;
    localparam int c_t_cmd_def    = 4000;
    localparam int c_t_clear_def  = 164000;
    localparam int c_t_init1_def  = 410000;
    localparam int c_t_init2_def  = 10000;

    localparam logic [7:0] c_cmd_func_set = 8'h28;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_line1    = 8'h80;
    localparam logic [7:0] c_cmd_line2    = 8'hC0;

    localparam logic [3:0] c_init_nib_8bit = 4'h3;
    localparam logic [3:0] c_init_nib_4bit = 4'h2;

    localparam logic [6:0] c_init_last   = 7'd3;
    localparam logic [6:0] c_config_last = 7'd7;
    localparam logic [6:0] c_frame_last  = 7'd67;

    typedef enum logic [1:0] {
        ST_PWRUP  = 2'd0,
        ST_INIT   = 2'd1,
        ST_CONFIG = 2'd2,
        ST_FRAME  = 2'd3
    } lcd_state_e;

    function automatic logic [7:0] config_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return c_cmd_func_set;
            2'd1:    return c_cmd_disp_on;
            2'd2:    return c_cmd_entry;
            default: return c_cmd_clear;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : Sends one nibble: setup, E strobe, hold, then a post-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx #(
    parameter int T_SETUP = 4,
    parameter int T_EHIGH = 25,
    parameter int T_HOLD  = 4,
    parameter int CW      = 21
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_start,
    input  logic          i_rs,
    input  logic [3:0]    i_nibble,
    input  logic [CW-1:0] i_wait,
    output logic          o_e,
    output logic          o_rs,
    output logic [3:0]    o_d,
    output logic          o_done
);

    localparam logic [2:0] c_ph_idle  = 3'd0;
    localparam logic [2:0] c_ph_setup = 3'd1;
    localparam logic [2:0] c_ph_ehigh = 3'd2;
    localparam logic [2:0] c_ph_hold  = 3'd3;
    localparam logic [2:0] c_ph_wait  = 3'd4;

    logic [2:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_wait;
    logic          r_e;
    logic          r_rs;
    logic [3:0]    r_d;
    logic          w_done;

    // Done marks the last post-wait cycle so the next nibble's setup follows with no gap.
    assign w_done = (r_phase == c_ph_wait) && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= c_ph_idle;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_d     <= 4'h0;
        end else if (i_start && ((r_phase == c_ph_idle) || w_done)) begin
            r_phase <= c_ph_setup;
            r_cnt   <= CW'(T_SETUP - 1);
            r_wait  <= i_wait;
            r_rs    <= i_rs;
            r_d     <= i_nibble;
        end else if (r_phase != c_ph_idle) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                case (r_phase)
                    c_ph_setup: begin
                        r_phase <= c_ph_ehigh;
                        r_cnt   <= CW'(T_EHIGH - 1);
                        r_e     <= 1'b1;
                    end
                    c_ph_ehigh: begin
                        r_phase <= c_ph_hold;
                        r_cnt   <= CW'(T_HOLD - 1);
                        r_e     <= 1'b0;
                    end
                    c_ph_hold: begin
                        r_phase <= c_ph_wait;
                        r_cnt   <= r_wait - CW'(1);
                    end
                    default: begin
                        r_phase <= c_ph_idle;
                    end
                endcase
            end
        end
    end

    assign o_e    = r_e;
    assign o_rs   = r_rs;
    assign o_d    = r_d;
    assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_writer
// Description : HD44780 16x2 4-bit driver: power-up init, then endless refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP  = c_t_pwrup_def,
    parameter int T_SETUP  = c_t_setup_def,
    parameter int T_EHIGH  = c_t_ehigh_def,
    parameter int T_HOLD   = c_t_hold_def,
    parameter int T_NIBBLE = c_t_nibble_def,
    parameter int T_CMD    = c_t_cmd_def,
    parameter int T_CLEAR  = c_t_clear_def,
    parameter int T_INIT1  = c_t_init1_def,
    parameter int T_INIT2  = c_t_init2_def
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [0:127] row_A,
    input  logic [0:127] row_B,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [3:0]   LCD_D,
    output logic         init_done,
    output logic         frame_sync
);

    localparam int c_t_max = max_int(max_int(max_int(T_PWRUP, T_SETUP), max_int(T_EHIGH, T_HOLD)),
                                     max_int(max_int(T_NIBBLE, T_CMD), max_int(T_CLEAR,
                                             max_int(T_INIT1, T_INIT2))));
    localparam int c_cw = $clog2(c_t_max + 1);

    lcd_state_e    r_state;
    logic [6:0]    r_idx;
    logic [c_cw-1:0] r_pwr_cnt;
    logic          r_snap;
    logic          r_init_done;
    logic [0:127]  r_row_a;
    logic [0:127]  r_row_b;

    lcd_state_e    w_nxt_state;
    logic [6:0]    w_nxt_idx;
    logic          w_issue;
    logic          w_tx_done;
    logic          w_rs;
    logic [3:0]    w_nibble;
    logic [c_cw-1:0] w_wait;
    logic [7:0]    w_byte;
    logic [5:0]    w_byte_idx;
    logic [3:0]    w_col;
    logic          w_config_end;

    assign w_issue = ((r_state == ST_PWRUP) && (r_pwr_cnt == c_cw'(T_PWRUP - 1))) || w_tx_done;
    assign w_config_end = w_tx_done && (r_state == ST_CONFIG) && (r_idx == c_config_last);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx + 7'd1;
        case (r_state)
            ST_PWRUP: begin
                w_nxt_state = ST_INIT;
                w_nxt_idx   = 7'd0;
            end
            ST_INIT: if (r_idx == c_init_last) begin
                w_nxt_state = ST_CONFIG;
                w_nxt_idx   = 7'd0;
            end
            ST_CONFIG: if (r_idx == c_config_last) begin
                w_nxt_state = ST_FRAME;
                w_nxt_idx   = 7'd0;
            end
            default: if (r_idx == c_frame_last) begin
                w_nxt_idx   = 7'd0;
            end
        endcase
    end

    // Decode the nibble that will be launched on the next issue, so there is no idle cycle.
    always_comb begin
        w_byte_idx = w_nxt_idx[6:1];
        w_col      = 4'h0;
        w_byte     = 8'h00;
        w_rs       = 1'b0;
        case (w_nxt_state)
            ST_CONFIG: w_byte = config_byte(w_byte_idx[1:0]);
            ST_FRAME: begin
                if (w_byte_idx == 6'd0) begin
                    w_byte = c_cmd_line1;
                end else if (w_byte_idx <= 6'd16) begin
                    w_col  = 4'(w_byte_idx - 6'd1);
                    w_byte = r_row_a[{w_col, 3'b000} +: 8];
                    w_rs   = 1'b1;
                end else if (w_byte_idx == 6'd17) begin
                    w_byte = c_cmd_line2;
                end else begin
                    w_col  = 4'(w_byte_idx - 6'd18);
                    w_byte = r_row_b[{w_col, 3'b000} +: 8];
                    w_rs   = 1'b1;
                end
            end
            default: w_byte = 8'h00;
        endcase

        w_nibble = w_nxt_idx[0] ? w_byte[3:0] : w_byte[7:4];
        if (!w_nxt_idx[0]) begin
            w_wait = c_cw'(T_NIBBLE);
        end else if ((w_nxt_state == ST_CONFIG) && (w_byte == c_cmd_clear)) begin
            w_wait = c_cw'(T_CLEAR);
        end else begin
            w_wait = c_cw'(T_CMD);
        end

        if (w_nxt_state == ST_INIT) begin
            w_nibble = (w_nxt_idx == c_init_last) ? c_init_nib_4bit : c_init_nib_8bit;
            case (w_nxt_idx)
                7'd0:    w_wait = c_cw'(T_INIT1);
                7'd1:    w_wait = c_cw'(T_INIT2);
                default: w_wait = c_cw'(T_CMD);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_PWRUP;
            r_idx       <= 7'd0;
            r_pwr_cnt   <= '0;
            r_snap      <= 1'b0;
            r_init_done <= 1'b0;
            r_row_a     <= '0;
            r_row_b     <= '0;
        end else begin
            if ((r_state == ST_PWRUP) && !w_issue) begin
                r_pwr_cnt <= r_pwr_cnt + c_cw'(1);
            end
            if (w_issue) begin
                r_state <= w_nxt_state;
                r_idx   <= w_nxt_idx;
            end
            // Rows are latched during the first setup cycle of the 0x80 byte.
            r_snap <= w_issue && (w_nxt_state == ST_FRAME) && (w_nxt_idx == 7'd0);
            if (r_snap) begin
                r_row_a <= row_A;
                r_row_b <= row_B;
            end
            if (w_config_end) begin
                r_init_done <= 1'b1;
            end
        end
    end

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_HOLD  (T_HOLD),
        .CW      (c_cw)
    ) u_nibble_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_issue),
        .i_rs     (w_rs),
        .i_nibble (w_nibble),
        .i_wait   (w_wait),
        .o_e      (LCD_E),
        .o_rs     (LCD_RS),
        .o_d      (LCD_D),
        .o_done   (w_tx_done)
    );

    assign LCD_RW     = 1'b0;
    assign init_done  = r_init_done || w_config_end;
    assign frame_sync = w_tx_done && (r_state == ST_FRAME) && (r_idx == c_frame_last);

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_frame_writer
// Description : Self-checking bench; pin activity is compared against a
//               cycle-accurate nibble-stream model built from the LCD protocol.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_frame_writer;

    localparam int T_PWRUP  = 20;
    localparam int T_SETUP  = 2;
    localparam int T_EHIGH  = 3;
    localparam int T_HOLD   = 2;
    localparam int T_NIBBLE = 4;
    localparam int T_CMD    = 10;
    localparam int T_CLEAR  = 30;
    localparam int T_INIT1  = 40;
    localparam int T_INIT2  = 15;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [0:127] row_A;
    logic [0:127] row_B;
    logic         LCD_E;
    logic         LCD_RS;
    logic         LCD_RW;
    logic [3:0]   LCD_D;
    logic         init_done;
    logic         frame_sync;

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .T_PWRUP (T_PWRUP), .T_SETUP (T_SETUP), .T_EHIGH (T_EHIGH),
        .T_HOLD  (T_HOLD),  .T_NIBBLE(T_NIBBLE), .T_CMD  (T_CMD),
        .T_CLEAR (T_CLEAR), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .row_A      (row_A),
        .row_B      (row_B),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_D      (LCD_D),
        .init_done  (init_done),
        .frame_sync (frame_sync)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected nibble stream: each entry is what one E pulse must carry.
    typedef struct {
        bit       rs;
        bit [3:0] d;
        int       wt;
        int       mark;   // 1: end of config, 2: end of frame
    } nib_t;

    nib_t exp_q[$];
    int   cyc, next_rise, rise_cyc, fall_cyc, chg_cyc, init_cyc, fs_cyc;
    int   fs_count = 0;
    logic prev_e, prev_rs;
    logic [3:0] prev_d;

    task automatic push_nib(input bit rs, input bit [3:0] d, input int wt, input int mark);
        nib_t n;
        n.rs = rs; n.d = d; n.wt = wt; n.mark = mark;
        exp_q.push_back(n);
    endtask

    task automatic push_byte(input bit [7:0] b, input bit rs, input int wt, input int mark);
        push_nib(rs, b[7:4], T_NIBBLE, 0);
        push_nib(rs, b[3:0], wt, mark);
    endtask

    task automatic build_frame(input logic [0:127] ra, input logic [0:127] rb);
        push_byte(8'h80, 1'b0, T_CMD, 0);
        for (int k = 0; k < 16; k++) push_byte(ra[8*k +: 8], 1'b1, T_CMD, 0);
        push_byte(8'hC0, 1'b0, T_CMD, 0);
        for (int k = 0; k < 16; k++) push_byte(rb[8*k +: 8], 1'b1, T_CMD, (k == 15) ? 2 : 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        push_nib(1'b0, 4'h3, T_INIT1, 0);
        push_nib(1'b0, 4'h3, T_INIT2, 0);
        push_nib(1'b0, 4'h3, T_CMD, 0);
        push_nib(1'b0, 4'h2, T_CMD, 0);
        push_byte(8'h28, 1'b0, T_CMD, 0);
        push_byte(8'h0C, 1'b0, T_CMD, 0);
        push_byte(8'h06, 1'b0, T_CMD, 0);
        push_byte(8'h01, 1'b0, T_CLEAR, 1);
        cyc       = 0;
        next_rise = T_PWRUP + T_SETUP;
        rise_cyc  = -1000;
        fall_cyc  = -1000;
        chg_cyc   = -1000;
        init_cyc  = -1;
        fs_cyc    = -1;
        prev_e    = 1'b0;
        prev_rs   = 1'b0;
        prev_d    = 4'h0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            model_reset();
            check_val("rst_e", LCD_E, 0);
            check_val("rst_rs", LCD_RS, 0);
            check_val("rst_d", LCD_D, 0);
            check_val("rst_init_done", init_done, 0);
            check_val("rst_frame_sync", frame_sync, 0);
        end else begin
            cyc++;
            check_val("lcd_rw", LCD_RW, 0);
            check_val("init_done", init_done, (init_cyc >= 0) && (cyc >= init_cyc));
            check_val("frame_sync", frame_sync, cyc == fs_cyc);
            if (frame_sync) fs_count++;
            if (exp_q.size() == 0 && cyc == next_rise - T_SETUP) build_frame(row_A, row_B);
            if ({LCD_RS, LCD_D} != {prev_rs, prev_d}) begin
                check_val("hold_window", (!LCD_E) && (cyc - fall_cyc >= T_HOLD), 1);
                chg_cyc = cyc;
            end
            if (LCD_E && !prev_e) begin
                check_val("setup_window", cyc - chg_cyc >= T_SETUP, 1);
                check_val("e_rise_cycle", cyc, next_rise);
                if (exp_q.size() != 0) begin
                    nib_t it;
                    it = exp_q.pop_front();
                    check_val("nibble_rs", LCD_RS, it.rs);
                    check_val("nibble_d", LCD_D, it.d);
                    next_rise = cyc + T_EHIGH + T_HOLD + it.wt + T_SETUP;
                    if (it.mark == 1) init_cyc = cyc + T_EHIGH + T_HOLD + it.wt - 1;
                    if (it.mark == 2) fs_cyc   = cyc + T_EHIGH + T_HOLD + it.wt - 1;
                end
                rise_cyc = cyc;
            end else if (cyc == next_rise) begin
                check_val("e_rise_missing", LCD_E, 1);
            end
            if (!LCD_E && prev_e) begin
                check_val("e_width", cyc - rise_cyc, T_EHIGH);
                fall_cyc = cyc;
            end
            prev_e  = LCD_E;
            prev_rs = LCD_RS;
            prev_d  = LCD_D;
        end
    end

    task automatic wait_fs(input int target, input int budget);
        int n;
        n = 0;
        while (fs_count < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (fs_count < target) check_val("frame_sync_timeout", fs_count, target);
    endtask

    task automatic random_rows();
        for (int k = 0; k < 16; k++) begin
            row_A[8*k +: 8] = 8'(32'h20 + $urandom_range(0, 94));
            row_B[8*k +: 8] = 8'(32'h20 + $urandom_range(0, 94));
        end
    endtask

    initial begin
        int n;
        model_reset();
        row_A   = "Fibo #01 is 0000";
        row_B   = "Fibo #02 is 0001";
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        wait_fs(1, 3000);
        // Mid-frame change (around byte 5): must appear only one frame later.
        repeat (5 * 28) @(posedge clk);
        @(negedge clk) row_A = "Fibo #03 is 0001";
        wait_fs(fs_count + 2, 2500);

        for (int f = 0; f < 3; f++) begin
            repeat ($urandom_range(20, 800)) @(posedge clk);
            @(negedge clk) random_rows();
            wait_fs(fs_count + 1, 1500);
        end

        // Async reset while E is high.
        repeat ($urandom_range(50, 600)) @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!LCD_E && n < 200);
        check_val("e_seen_before_reset", LCD_E, 1);
        #1 reset_n = 1'b0;
        #1;
        check_val("async_e", LCD_E, 0);
        check_val("async_rs", LCD_RS, 0);
        check_val("async_d", LCD_D, 0);
        check_val("async_init_done", init_done, 0);
        check_val("async_frame_sync", frame_sync, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        random_rows();
        wait_fs(fs_count + 2, 4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

HD44780-compatible character-LCD driver for the 16x2 panel in 4-bit write-only mode. It performs the power-up initialization sequence, then continuously refreshes the display from two 128-bit ASCII row buffers supplied by the application logic. It sits between the application (which only updates row strings) and the LCD pins. All pin timing is derived from cycle-count parameters.

## Interface
- T_PWRUP, 1_500_000: cycles idle after reset before the first nibble (15 ms @100 MHz)
- T_SETUP, 4: cycles RS/D stable with E low before E rises
- T_EHIGH, 25: cycles E held high
- T_HOLD, 4: cycles RS/D held after E falls
- T_NIBBLE, 100: gap cycles between high and low nibble of a byte
- T_CMD, 4000: wait after a byte or init nibble (40 us)
- T_CLEAR, 164000: wait after the clear command 0x01 (1.64 ms)
- T_INIT1, 410000: wait after the first init nibble (4.1 ms)
- T_INIT2, 10000: wait after the second init nibble (100 us)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- row_A  in  [0:127]  line 1 text; row_A[0:7] is the leftmost character
- row_B  in  [0:127]  line 2 text, same ordering
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_D  out  [3:0]  data nibble
- init_done  out  1  high once configuration bytes are complete, stays high until reset
- frame_sync  out  1  one-cycle pulse when the last wait of a refresh frame ends

## Operation
- Top FSM: PWRUP -> INIT -> CONFIG -> FRAME, with FRAME looping forever.
- PWRUP: wait T_PWRUP cycles, all outputs at reset values.
- INIT: four single nibbles with RS=0: 0x3 (wait T_INIT1), 0x3 (wait T_INIT2), 0x3 (wait T_CMD), 0x2 (wait T_CMD).
- CONFIG: bytes with RS=0, in order 0x28, 0x0C, 0x06, 0x01. Each waits T_CMD except 0x01, which waits T_CLEAR. init_done rises on the cycle the 0x01 wait ends.
- FRAME: 34 bytes:
  - 0x80 (RS=0)
  - row_A chars 0..15 (RS=1)
  - 0xC0 (RS=0)
  - row_B chars 0..15 (RS=1)
  - Every frame byte waits T_CMD.
- Snapshot: row_A and row_B are captured into internal registers on the first cycle of each frame (the 0x80 setup cycle). Input changes during a frame appear only in the next frame; no tearing within a line.
- A byte is sent as two nibbles, high nibble first.
- Reset (async) at any point, including mid-E-pulse:
  - LCD_E, LCD_RS, LCD_RW, LCD_D, init_done, frame_sync are all forced to 0.
  - The FSM returns to PWRUP and runs the full sequence again.

## Timing
- Nibble transfer, starting at cycle 0:
  - RS/D driven with E=0 for T_SETUP cycles.
  - E=1 for T_EHIGH cycles.
  - E=0 with RS/D unchanged for T_HOLD cycles.
  - Nibble length N = T_SETUP+T_EHIGH+T_HOLD.
- Byte = N + T_NIBBLE + N + post-wait (T_CMD or T_CLEAR).
- After the post-wait, the next transfer's setup starts on the following cycle.
- LCD_D and LCD_RS change only on the first setup cycle of a nibble. They hold their last value during gaps and waits.
- LCD_E is registered and glitch-free. It never goes high outside the T_EHIGH window.
- frame_sync fires on the final cycle of the last row_B character's T_CMD wait. The next frame's snapshot happens on the next cycle.
- Counter width must hold the largest parameter; T_PWRUP at its default needs ≥21 bits. Parameters are ≥1; a value of 1 means one cycle.

## Structure
- Package lcd_pkg holds:
  - command constants (0x28, 0x0C, 0x06, 0x01, 0x80, 0xC0)
  - init nibble values
  - top-FSM state enum
  - default timing values
- Sub-module lcd_nibble_tx:
  - inputs: start, rs, nibble, post-wait count
  - outputs: E/RS/D, done pulse
  - owns the setup/E-high/hold/wait counter
- The top level sequences nibbles and bytes and owns the snapshot registers.

## Test plan
- Bench parameters for all tests: T_PWRUP=20, T_SETUP=2, T_EHIGH=3, T_HOLD=2, T_NIBBLE=4, T_CMD=10, T_CLEAR=30, T_INIT1=40, T_INIT2=15.
- Reset held low -> all outputs 0. Release -> first E rise exactly 20+2 cycles later, with D=0x3, RS=0.
- Full init -> decoded nibble stream is 3,3,3,2,2,8,0,C,0,6,0,1. The gap after the final nibble of 0x01 is 30 cycles. init_done rises at its end.
- row_A="Fibo #01 is 0000", row_B="Fibo #02 is 0001" -> decoded frame is 0x80, "Fibo #01 is 0000", 0xC0, "Fibo #02 is 0001" with RS 0/1 correct. frame_sync pulses once per 34 bytes.
- Change row_A to "Fibo #03 is 0001" during byte 5 of a frame -> current frame still shows "#01". The next frame shows "#03".
- Assert reset_n low while E=1 mid-frame -> E drops the same cycle (async). After release, the full PWRUP/INIT sequence repeats and init_done stays 0 until CONFIG ends.
- Check every E pulse -> width exactly 3 cycles, D/RS stable from 2 cycles before E rises until 2 cycles after E falls, LCD_RW always 0.
